// File: rtl/adsr_env_pkg.sv
// Shared definitions for the ADSR envelope voice: default widths and state encoding.
package adsr_env_pkg;

  localparam int unsigned DEF_SAMPLE_W = 16;
  localparam int unsigned DEF_ENV_W    = 16;

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_ATTACK  = 3'd1,
    ST_DECAY   = 3'd2,
    ST_SUSTAIN = 3'd3,
    ST_RELEASE = 3'd4
  } env_state_e;

endpackage

// File: rtl/adsr_env_scale.sv
// Combinational gain stage: signed sample times unsigned envelope, floor-shifted back to sample width.
module adsr_env_scale
  import adsr_env_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
  parameter int unsigned ENV_W    = DEF_ENV_W
) (
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic [ENV_W-1:0]    level,
  output logic [SAMPLE_W-1:0] scaled_c
);

  localparam int unsigned PROD_W = SAMPLE_W + ENV_W + 1;

  logic signed [PROD_W-1:0] prod_c;

  // Level gets a zero MSB so it stays non-negative in the signed product.
  assign prod_c   = PROD_W'($signed(sample_in)) * PROD_W'($signed({1'b0, level}));
  assign scaled_c = SAMPLE_W'(prod_c >>> ENV_W);

endmodule

// File: rtl/adsr_env.sv
// One-voice ADSR envelope generator and amplitude modulator, advanced on the in_ready strobe.
module adsr_env
  import adsr_env_pkg::*;
#(
  parameter int unsigned SAMPLE_W = DEF_SAMPLE_W,
  parameter int unsigned ENV_W    = DEF_ENV_W
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                in_ready,
  input  logic [SAMPLE_W-1:0] sample_in,
  input  logic                gate,
  input  logic [ENV_W-1:0]    attack_step,
  input  logic [ENV_W-1:0]    decay_step,
  input  logic [ENV_W-1:0]    sustain_level,
  input  logic [ENV_W-1:0]    release_step,
  output logic [SAMPLE_W-1:0] sample_out,
  output logic                out_ready,
  output logic [ENV_W-1:0]    env_level,
  output logic [2:0]          env_state,
  output logic                busy
);

  localparam int unsigned EXT_W = ENV_W + 1;

  env_state_e          state_q, state_d;
  logic [ENV_W-1:0]    level_q, level_d;
  logic                gate_q, gate_d;
  logic [SAMPLE_W-1:0] sample_out_q, sample_out_d;
  logic                out_ready_q, out_ready_d;
  logic                busy_q, busy_d;

  logic [SAMPLE_W-1:0] scaled_c;
  logic                rise_c, fall_c;
  logic [EXT_W-1:0]    lvl_x_c, max_x_c, att_sum_x_c, dec_floor_x_c, rel_x_c;

  // Gain applied with the level held before this strobe's update.
  adsr_env_scale #(
    .SAMPLE_W (SAMPLE_W),
    .ENV_W    (ENV_W)
  ) u_scale (
    .sample_in (sample_in),
    .level     (level_q),
    .scaled_c  (scaled_c)
  );

  assign rise_c        = gate & ~gate_q;
  assign fall_c        = ~gate & gate_q;
  assign lvl_x_c       = {1'b0, level_q};
  assign max_x_c       = {1'b0, {ENV_W{1'b1}}};
  assign att_sum_x_c   = lvl_x_c + {1'b0, attack_step};
  assign dec_floor_x_c = {1'b0, sustain_level} + {1'b0, decay_step};
  assign rel_x_c       = {1'b0, release_step};

  // Next-state, level and output computation; everything holds unless in_ready.
  always_comb begin
    state_d      = state_q;
    level_d      = level_q;
    gate_d       = gate_q;
    sample_out_d = sample_out_q;
    out_ready_d  = in_ready;

    if (in_ready) begin
      gate_d       = gate;
      sample_out_d = scaled_c;

      if (rise_c) begin
        // Retrigger keeps the current level so there is no step in the output.
        state_d = ST_ATTACK;
      end else if (fall_c && (state_q == ST_ATTACK || state_q == ST_DECAY ||
                              state_q == ST_SUSTAIN)) begin
        state_d = ST_RELEASE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            level_d = '0;
          end
          ST_ATTACK: begin
            if (attack_step == '0 || att_sum_x_c >= max_x_c) begin
              level_d = {ENV_W{1'b1}};
              state_d = ST_DECAY;
            end else begin
              level_d = att_sum_x_c[ENV_W-1:0];
            end
          end
          ST_DECAY: begin
            if (decay_step == '0 || lvl_x_c <= dec_floor_x_c) begin
              level_d = sustain_level;
              state_d = ST_SUSTAIN;
            end else begin
              level_d = level_q - decay_step;
            end
          end
          ST_SUSTAIN: begin
            level_d = sustain_level;
          end
          ST_RELEASE: begin
            if (release_step == '0 || lvl_x_c <= rel_x_c) begin
              level_d = '0;
              state_d = ST_IDLE;
            end else begin
              level_d = level_q - release_step;
            end
          end
          default: begin
            level_d = '0;
            state_d = ST_IDLE;
          end
        endcase
      end
    end

    busy_d = (state_d != ST_IDLE);
  end

  // State and datapath registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q      <= ST_IDLE;
      level_q      <= '0;
      gate_q       <= 1'b0;
      sample_out_q <= '0;
      out_ready_q  <= 1'b0;
      busy_q       <= 1'b0;
    end else begin
      state_q      <= state_d;
      level_q      <= level_d;
      gate_q       <= gate_d;
      sample_out_q <= sample_out_d;
      out_ready_q  <= out_ready_d;
      busy_q       <= busy_d;
    end
  end

  assign sample_out = sample_out_q;
  assign out_ready  = out_ready_q;
  assign env_level  = level_q;
  assign env_state  = state_q;
  assign busy       = busy_q;

endmodule

// File: tb/tb_adsr_env.sv
// Directed bench for adsr_env: envelope shape, retrigger, reset and gain scaling.
module tb_adsr_env;

  logic        clk;
  logic        reset;
  logic        in_ready;
  logic [15:0] sample_in;
  logic        gate;
  logic [15:0] attack_step;
  logic [15:0] decay_step;
  logic [15:0] sustain_level;
  logic [15:0] release_step;
  logic [15:0] sample_out;
  logic        out_ready;
  logic [15:0] env_level;
  logic [2:0]  env_state;
  logic        busy;

  int n_checks = 0;
  int n_pass   = 0;

  adsr_env #(
    .SAMPLE_W (16),
    .ENV_W    (16)
  ) dut (
    .clk           (clk),
    .reset         (reset),
    .in_ready      (in_ready),
    .sample_in     (sample_in),
    .gate          (gate),
    .attack_step   (attack_step),
    .decay_step    (decay_step),
    .sustain_level (sustain_level),
    .release_step  (release_step),
    .sample_out    (sample_out),
    .out_ready     (out_ready),
    .env_level     (env_level),
    .env_state     (env_state),
    .busy          (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) $display("FAIL %s: got %h want %h", tag, got, exp);
    else n_pass++;
  endtask

  task automatic check_env(input string tag, input logic [2:0] st, input logic [15:0] lvl);
    check_eq({tag, ".state"}, 32'(env_state), 32'(st));
    check_eq({tag, ".level"}, 32'(env_level), 32'(lvl));
  endtask

  // One in_ready strobe; returns at the next falling edge, when out_ready should be high.
  task automatic strobe(input logic g, input logic [15:0] s);
    @(negedge clk);
    gate      = g;
    sample_in = s;
    in_ready  = 1'b1;
    @(negedge clk);
    in_ready  = 1'b0;
  endtask

  initial begin
    reset         = 1'b0;
    in_ready      = 1'b0;
    gate          = 1'b0;
    sample_in     = '0;
    attack_step   = 16'h2000;
    decay_step    = 16'h1000;
    sustain_level = 16'h8000;
    release_step  = 16'h4000;
    repeat (3) @(negedge clk);
    check_env("rst", 3'd0, 16'h0000);
    check_eq("rst.out", 32'(sample_out), 32'h0);
    check_eq("rst.rdy", 32'(out_ready), 32'h0);
    check_eq("rst.busy", 32'(busy), 32'h0);
    reset = 1'b1;

    // Note-on: rise keeps level 0; scaling by level 0 gives 0.
    strobe(1'b1, 16'h4000);
    check_eq("on.rdy", 32'(out_ready), 32'h1);
    check_eq("on.out", 32'(sample_out), 32'h0);
    check_env("on", 3'd1, 16'h0000);
    check_eq("on.busy", 32'(busy), 32'h1);
    @(negedge clk);
    check_eq("on.rdy_drop", 32'(out_ready), 32'h0);

    // Attack ramp, saturating on the eighth step.
    for (int i = 1; i <= 7; i++) begin
      strobe(1'b1, 16'h0000);
      check_env("atk", 3'd1, 16'(i * 32'h2000));
    end
    strobe(1'b1, 16'h0000);
    check_env("atk_sat", 3'd2, 16'hFFFF);

    // Decay, first strobe also scales 0x4000 by full level.
    strobe(1'b1, 16'h4000);
    check_eq("scale_full_pos", 32'(sample_out), 32'h3FFF);
    check_env("dec1", 3'd2, 16'hEFFF);
    for (int k = 2; k <= 7; k++) begin
      strobe(1'b1, 16'h0000);
      check_env("dec", 3'd2, 16'(32'hFFFF - k * 32'h1000));
    end
    strobe(1'b1, 16'h0000);
    check_env("dec_end", 3'd3, 16'h8000);

    // Sustain: half gain, floor of negative half, and live tracking of sustain_level.
    strobe(1'b1, 16'h7FFF);
    check_eq("scale_half_pos", 32'(sample_out), 32'h3FFF);
    check_env("sus", 3'd3, 16'h8000);
    sustain_level = 16'h9000;
    strobe(1'b1, 16'hFFFF);
    check_eq("scale_floor_neg", 32'(sample_out), 32'hFFFF);
    check_env("sus_track", 3'd3, 16'h9000);
    sustain_level = 16'h8000;
    strobe(1'b1, 16'h0000);
    check_env("sus_back", 3'd3, 16'h8000);

    // Gate glitch between strobes is ignored.
    @(negedge clk); gate = 1'b0;
    @(negedge clk); gate = 1'b1;
    @(negedge clk);
    check_env("glitch", 3'd3, 16'h8000);
    check_eq("glitch.rdy", 32'(out_ready), 32'h0);

    // Release.
    strobe(1'b0, 16'h0000);
    check_env("rel0", 3'd4, 16'h8000);
    strobe(1'b0, 16'h0000);
    check_env("rel1", 3'd4, 16'h4000);
    strobe(1'b0, 16'h0000);
    check_env("rel2", 3'd0, 16'h0000);
    check_eq("rel2.busy", 32'(busy), 32'h0);
    strobe(1'b0, 16'h0000);
    check_env("idle_hold", 3'd0, 16'h0000);

    // Retrigger from RELEASE at 0x3000.
    attack_step = 16'h3000;
    strobe(1'b1, 16'h0000);
    check_env("rt_on", 3'd1, 16'h0000);
    strobe(1'b1, 16'h0000);
    check_env("rt_atk", 3'd1, 16'h3000);
    strobe(1'b0, 16'h0000);
    check_env("rt_rel", 3'd4, 16'h3000);
    attack_step = 16'h2000;
    strobe(1'b1, 16'h0000);
    check_env("rt_rise", 3'd1, 16'h3000);
    strobe(1'b1, 16'h4000);
    check_env("rt_next", 3'd1, 16'h5000);
    check_eq("rt_scale", 32'(sample_out), 32'h0C00);

    // Reset mid-attack at level 0x5000.
    @(negedge clk); reset = 1'b0;
    @(negedge clk);
    check_env("mid_rst", 3'd0, 16'h0000);
    check_eq("mid_rst.out", 32'(sample_out), 32'h0);
    check_eq("mid_rst.rdy", 32'(out_ready), 32'h0);
    reset = 1'b1;

    // Zero steps act instantly.
    attack_step  = 16'h0000;
    decay_step   = 16'h0000;
    strobe(1'b1, 16'h0000);
    check_env("inst_on", 3'd1, 16'h0000);
    strobe(1'b1, 16'h0000);
    check_env("inst_atk", 3'd2, 16'hFFFF);
    strobe(1'b1, 16'hC000);
    check_eq("scale_full_neg", 32'(sample_out), 32'hC000);
    check_env("inst_dec", 3'd3, 16'h8000);
    release_step = 16'h0000;
    strobe(1'b0, 16'h0000);
    check_env("inst_fall", 3'd4, 16'h8000);
    strobe(1'b0, 16'h0000);
    check_env("inst_rel", 3'd0, 16'h0000);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
